ow_intf_word: RTL and testbench
===============================

OW_INTF_WORD -- requirements
Module: ow_intf_word

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- DATA_W, 8: bits per read/write transfer, LSB first.
- CNT_RST_LOW, 24000: reset-pulse low time in clk cycles (480 us @ 50 MHz).
- CNT_RST_WAIT, 24000: released wait after the reset pulse.
- CNT_PRES_SAMPLE, 3500: presence sample point, counted within the wait.
- CNT_SLOT, 3250: bit-slot length.
- CNT_LOW_1, 100: low time for write-1 and read slots.
- CNT_WR0_LOW, 3000: low time for write-0 slots.
- CNT_RD_SAMPLE, 700: read sample point, counted within the slot.
- CNT_RECOVERY, 100: released recovery time between slots.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- rst_en, in, 1: start a bus reset/presence sequence.
- wr_en, in, 1: start a DATA_W-bit write.
- wdata, in, DATA_W: write data.
- rd_en, in, 1: start a DATA_W-bit read.
- rdata, out, DATA_W: last read word.
- rdata_vld, out, 1: one-cycle strobe marking rdata valid.
- presence, out, 1: 1 = slave answered the last reset.
- presence_vld, out, 1: one-cycle strobe marking presence valid.
- dq_out, out, 1: constant 0.
- dq_out_en, out, 1: 1 = drive the bus low.
- dq_in, in, 1: sampled bus level.
- rdy, out, 1: idle; a command is accepted this cycle.

Function
REQ-003 FSM states SHALL be IDLE, RST_LOW, RST_WAIT, SLOT, RECOV; rdy SHALL be 1 exactly when state is IDLE.
REQ-004 A command SHALL be accepted only when rdy=1; on simultaneous requests the priority SHALL be rst_en > wr_en > rd_en; requests while rdy=0 SHALL be ignored.
REQ-005 Accepting a command SHALL latch wdata and the op type, clear the bit counter, and enter RST_LOW (reset) or SLOT (write/read) on the next edge.
REQ-006 RST_LOW SHALL hold dq_out_en=1 for exactly CNT_RST_LOW cycles, then enter RST_WAIT.
REQ-007 RST_WAIT SHALL hold dq_out_en=0 for CNT_RST_WAIT cycles.
REQ-008 In RST_WAIT, the block SHALL register presence=~dq_in at phase count CNT_PRES_SAMPLE-1.
REQ-009 When RST_WAIT completes, the block SHALL enter IDLE and pulse presence_vld for 1 cycle, coincident with the first cycle of rdy=1.
REQ-010 Each SLOT SHALL last CNT_SLOT cycles, with dq_out_en=1 for the first CNT_WR0_LOW cycles on a write-0 and for the first CNT_LOW_1 cycles otherwise.
REQ-011 In read mode, dq_in SHALL be sampled at slot count CNT_RD_SAMPLE-1 and shifted into the MSB of a right-shifting register (LSB first).
REQ-012 RECOV SHALL hold dq_out_en=0 for CNT_RECOVERY cycles, then go to SLOT for the next bit, or to IDLE after bit DATA_W-1.
REQ-013 A transfer SHALL take exactly DATA_W*(CNT_SLOT+CNT_RECOVERY) busy cycles.
REQ-014 At read completion, rdata SHALL update and rdata_vld SHALL pulse for 1 cycle, coincident with the first rdy=1 cycle; rdata SHALL hold its value otherwise.
REQ-015 dq_out SHALL be constant 0; the bus SHALL be driven only through dq_out_en.
REQ-016 The phase counter SHALL be sized $clog2 of the largest CNT_* parameter and SHALL clear on every state change.
REQ-017 The parameter set SHALL satisfy CNT_LOW_1 < CNT_RD_SAMPLE < CNT_WR0_LOW < CNT_SLOT and CNT_PRES_SAMPLE < CNT_RST_WAIT; a simulation-time check SHALL flag any violation.

Reset
REQ-018 While rst=1, on the next edge: state=IDLE, rdy=1, dq_out_en=0, rdata=0, rdata_vld=0, presence=0, presence_vld=0, all counters 0.
REQ-019 rst asserted mid-operation SHALL abort the operation and release the bus on the next edge, with no rdata_vld or presence_vld strobe.

Structure
REQ-020 Package ow_pkg SHALL hold the state enum and the 50 MHz default timing constants.
REQ-021 Phase timing SHALL be implemented in one sub-module, ow_phase_cnt (load/clear, terminal-count flag).

Verification (DATA_W=8; CNT_RST_LOW=25, CNT_RST_WAIT=18, CNT_PRES_SAMPLE=6, CNT_SLOT=15, CNT_LOW_1=2, CNT_RD_SAMPLE=4, CNT_WR0_LOW=12, CNT_RECOVERY=2)
REQ-022 rst_en with the slave pulling dq_in low during wait cycles 2..10 -> dq_out_en high for exactly 25 cycles; presence=1; presence_vld pulses once, 43 cycles after the first busy cycle.
REQ-023 rst_en with dq_in held at 1 -> presence=0 with a single presence_vld strobe.
REQ-024 wr_en, wdata=8'hA5 -> low widths 2,12,2,12,12,2,12,2 cycles; slot period 17 cycles; rdy low for 136 cycles.
REQ-025 rd_en with a slave model returning 8'h3C -> every low pulse 2 cycles; rdata=8'h3C; exactly one rdata_vld pulse.
REQ-026 rst_en, wr_en and rd_en asserted in the same cycle -> only the reset sequence runs; a wr_en issued while busy is ignored.
REQ-027 rst asserted during bit 3 of a write -> dq_out_en=0 and rdy=1 on the next edge, with no strobes.

Source files
------------

// File: rtl/ow_pkg.sv
// 1-Wire word interface package: FSM state type, operation type and the
// default timing constants for a 50 MHz clock.
package ow_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRstLow,
        StRstWait,
        StSlot,
        StRecov
    } ow_state_e;

    typedef enum logic [1:0] {
        OpRst,
        OpWr,
        OpRd
    } ow_op_e;

    // Default timing in clk cycles at 50 MHz.
    localparam int unsigned OW_DATA_W          = 8;
    localparam int unsigned OW_CNT_RST_LOW     = 24000;
    localparam int unsigned OW_CNT_RST_WAIT    = 24000;
    localparam int unsigned OW_CNT_PRES_SAMPLE = 3500;
    localparam int unsigned OW_CNT_SLOT        = 3250;
    localparam int unsigned OW_CNT_LOW_1       = 100;
    localparam int unsigned OW_CNT_WR0_LOW     = 3000;
    localparam int unsigned OW_CNT_RD_SAMPLE   = 700;
    localparam int unsigned OW_CNT_RECOVERY    = 100;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ow_phase_cnt.sv
// Phase counter for the 1-Wire FSM.
//   clk, rst : clock and synchronous active-high reset
//   clr      : clear to zero (has priority over en)
//   en       : count up by one
//   last     : terminal value of the current phase
//   cnt      : current phase count
//   tc       : high while cnt equals last
module ow_phase_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == last);

endmodule

// File: rtl/ow_intf_word.sv
// 1-Wire master, word level: bus reset with presence detect, DATA_W-bit
// write and DATA_W-bit read, LSB first.
//   rst_en / wr_en / rd_en : command requests, accepted only while rdy=1
//   wdata                  : write word, latched on accept
//   rdata, rdata_vld       : last read word and its one-cycle strobe
//   presence, presence_vld : presence result and its one-cycle strobe
//   dq_out, dq_out_en      : open-drain bus drive (dq_out is always 0)
//   dq_in                  : sampled bus level
//   rdy                    : idle, ready for a command
module ow_intf_word
    import ow_pkg::*;
#(
    parameter int unsigned DATA_W          = OW_DATA_W,
    parameter int unsigned CNT_RST_LOW     = OW_CNT_RST_LOW,
    parameter int unsigned CNT_RST_WAIT    = OW_CNT_RST_WAIT,
    parameter int unsigned CNT_PRES_SAMPLE = OW_CNT_PRES_SAMPLE,
    parameter int unsigned CNT_SLOT        = OW_CNT_SLOT,
    parameter int unsigned CNT_LOW_1       = OW_CNT_LOW_1,
    parameter int unsigned CNT_WR0_LOW     = OW_CNT_WR0_LOW,
    parameter int unsigned CNT_RD_SAMPLE   = OW_CNT_RD_SAMPLE,
    parameter int unsigned CNT_RECOVERY    = OW_CNT_RECOVERY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_vld,
    output logic              presence,
    output logic              presence_vld,
    output logic              dq_out,
    output logic              dq_out_en,
    input  logic              dq_in,
    output logic              rdy
);

    localparam int unsigned CNT_MAX =
        max2(max2(max2(CNT_RST_LOW, CNT_RST_WAIT), max2(CNT_PRES_SAMPLE, CNT_SLOT)),
             max2(max2(CNT_LOW_1, CNT_WR0_LOW), max2(CNT_RD_SAMPLE, CNT_RECOVERY)));
    localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] LAST_RST_LOW  = CNT_W'(CNT_RST_LOW - 1);
    localparam logic [CNT_W-1:0] LAST_RST_WAIT = CNT_W'(CNT_RST_WAIT - 1);
    localparam logic [CNT_W-1:0] LAST_PRES     = CNT_W'(CNT_PRES_SAMPLE - 1);
    localparam logic [CNT_W-1:0] LAST_SLOT     = CNT_W'(CNT_SLOT - 1);
    localparam logic [CNT_W-1:0] LAST_RD       = CNT_W'(CNT_RD_SAMPLE - 1);
    localparam logic [CNT_W-1:0] LAST_RECOV    = CNT_W'(CNT_RECOVERY - 1);
    localparam logic [CNT_W-1:0] LEN_LOW_1     = CNT_W'(CNT_LOW_1);
    localparam logic [CNT_W-1:0] LEN_WR0_LOW   = CNT_W'(CNT_WR0_LOW);
    localparam logic [BIT_W-1:0] LAST_BIT      = BIT_W'(DATA_W - 1);

    // Timing relations the slot and reset sequencing depend on.
    if (!(CNT_LOW_1 < CNT_RD_SAMPLE && CNT_RD_SAMPLE < CNT_WR0_LOW &&
          CNT_WR0_LOW < CNT_SLOT && CNT_PRES_SAMPLE < CNT_RST_WAIT &&
          CNT_LOW_1 >= 1 && CNT_PRES_SAMPLE >= 1 && CNT_RST_LOW >= 1 &&
          CNT_RECOVERY >= 1 && DATA_W >= 2)) begin : g_param_err
        $error("ow_intf_word: inconsistent timing parameters");
    end

    ow_state_e          state_q, state_d;
    ow_op_e             op_q;
    logic [DATA_W-1:0]  sh_q;
    logic [BIT_W-1:0]   bit_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               rdata_vld_q;
    logic               presence_q;
    logic               presence_vld_q;

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_last;
    logic [CNT_W-1:0]   low_len;
    logic               tc;
    logic               accept;

    ow_phase_cnt #(
        .W (CNT_W)
    ) u_phase_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_d != state_q),
        .en   (state_q != StIdle),
        .last (cnt_last),
        .cnt  (cnt),
        .tc   (tc)
    );

    assign accept = (state_q == StIdle) && (rst_en || wr_en || rd_en);

    // Write-0 slots hold the bus low long; write-1 and read slots only briefly.
    assign low_len = (op_q == OpWr && !sh_q[0]) ? LEN_WR0_LOW : LEN_LOW_1;

    always_comb begin
        cnt_last  = '0;
        state_d   = state_q;
        dq_out_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rst_en) begin
                    state_d = StRstLow;
                end else if (wr_en || rd_en) begin
                    state_d = StSlot;
                end
            end
            StRstLow: begin
                cnt_last  = LAST_RST_LOW;
                dq_out_en = 1'b1;
                if (tc) state_d = StRstWait;
            end
            StRstWait: begin
                cnt_last = LAST_RST_WAIT;
                if (tc) state_d = StIdle;
            end
            StSlot: begin
                cnt_last  = LAST_SLOT;
                dq_out_en = (cnt < low_len);
                if (tc) state_d = StRecov;
            end
            StRecov: begin
                cnt_last = LAST_RECOV;
                if (tc) state_d = (bit_q == LAST_BIT) ? StIdle : StSlot;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            op_q           <= OpRst;
            sh_q           <= '0;
            bit_q          <= '0;
            rdata_q        <= '0;
            rdata_vld_q    <= 1'b0;
            presence_q     <= 1'b0;
            presence_vld_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rdata_vld_q    <= 1'b0;
            presence_vld_q <= 1'b0;
            if (accept) begin
                sh_q  <= wdata;
                bit_q <= '0;
                op_q  <= rst_en ? OpRst : (wr_en ? OpWr : OpRd);
            end
            if (state_q == StRstWait) begin
                if (cnt == LAST_PRES) presence_q <= ~dq_in;
                if (tc) presence_vld_q <= 1'b1;
            end
            if (state_q == StSlot) begin
                // Reads shift in at the sample point; writes retire a bit at slot end.
                if (op_q == OpRd && cnt == LAST_RD) begin
                    sh_q <= {dq_in, sh_q[DATA_W-1:1]};
                end else if (op_q == OpWr && tc) begin
                    sh_q <= {1'b0, sh_q[DATA_W-1:1]};
                end
            end
            if (state_q == StRecov && tc) begin
                if (bit_q == LAST_BIT) begin
                    if (op_q == OpRd) begin
                        rdata_q     <= sh_q;
                        rdata_vld_q <= 1'b1;
                    end
                end else begin
                    bit_q <= bit_q + 1'b1;
                end
            end
        end
    end

    assign rdy          = (state_q == StIdle);
    assign dq_out       = 1'b0;
    assign rdata        = rdata_q;
    assign rdata_vld    = rdata_vld_q;
    assign presence     = presence_q;
    assign presence_vld = presence_vld_q;

endmodule

// File: tb/tb_ow_intf_word.sv
module tb_ow_intf_word;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_en = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       rdata_vld;
    logic       presence;
    logic       presence_vld;
    logic       dq_out;
    logic       dq_out_en;
    logic       dq_in;
    logic       rdy;

    // Bus model: released high unless master or slave pulls low.
    logic slave_pull = 1'b0;
    logic pres_pull  = 1'b0;
    assign dq_in = ~(dq_out_en | slave_pull | pres_pull);

    always #5 clk = ~clk;

    ow_intf_word #(
        .DATA_W          (8),
        .CNT_RST_LOW     (25),
        .CNT_RST_WAIT    (18),
        .CNT_PRES_SAMPLE (6),
        .CNT_SLOT        (15),
        .CNT_LOW_1       (2),
        .CNT_RD_SAMPLE   (4),
        .CNT_WR0_LOW     (12),
        .CNT_RECOVERY    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rst_en       (rst_en),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rdata_vld    (rdata_vld),
        .presence     (presence),
        .presence_vld (presence_vld),
        .dq_out       (dq_out),
        .dq_out_en    (dq_out_en),
        .dq_in        (dq_in),
        .rdy          (rdy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboards for the two result strobes.
    logic       pres_exp_q[$];
    logic [7:0] rd_exp_q[$];

    int   widths[$];
    int   rises[$];
    int   cyc = 0;
    int   run = 0;
    logic en_prev = 1'b0;
    int   pres_strobes = 0;
    int   rd_strobes = 0;

    // Slave behaviour controls.
    logic       pres_mode = 1'b0;
    int         wc = 1000;
    logic       rd_mode = 1'b0;
    logic [7:0] rd_word = 8'h00;
    logic [2:0] bit_idx = 3'd0;
    int         pull_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor and slave model, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (dq_out_en === 1'b1) run++;
        if (en_prev && dq_out_en === 1'b0) begin
            widths.push_back(run);
            run = 0;
        end
        if (!en_prev && dq_out_en === 1'b1) rises.push_back(cyc);

        // Presence pulse: slave holds the bus low during wait cycles 2..10.
        if (pres_mode && en_prev && dq_out_en === 1'b0) wc = 0;
        else if (wc < 1000) wc++;
        pres_pull = pres_mode && (wc >= 2) && (wc <= 10);

        // Read slave: answer a 0 bit by holding the bus low past the sample point.
        if (rd_mode && !en_prev && dq_out_en === 1'b1) begin
            if (!rd_word[bit_idx]) pull_cnt = 6;
            bit_idx++;
        end else if (pull_cnt > 0) begin
            pull_cnt--;
        end
        slave_pull = (pull_cnt > 0);

        if (presence_vld === 1'b1) begin
            pres_strobes++;
            check("presence_vld_with_rdy", rdy, 1);
            if (pres_exp_q.size() == 0) check("unexpected_presence_vld", 1, 0);
            else check("presence_value", presence, pres_exp_q.pop_front());
        end
        if (rdata_vld === 1'b1) begin
            rd_strobes++;
            check("rdata_vld_with_rdy", rdy, 1);
            if (rd_exp_q.size() == 0) check("unexpected_rdata_vld", 1, 0);
            else check("rdata_value", rdata, rd_exp_q.pop_front());
        end
        en_prev = (dq_out_en === 1'b1);
    end

    // Caller is at a negedge; request is seen at the next posedge.
    task automatic issue(input logic r, input logic w, input logic rd, input logic [7:0] d);
        rst_en = r;
        wr_en  = w;
        rd_en  = rd;
        wdata  = d;
        @(negedge clk);
        rst_en = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
    endtask

    task automatic wait_idle(output int busy);
        busy = 0;
        while (rdy !== 1'b1 && busy < 2000) begin
            busy++;
            @(negedge clk);
        end
        if (busy >= 2000) check("wait_idle_timeout", 0, 1);
    endtask

    int busy;
    int ps0;
    int rs0;
    int exp_w[8] = '{2, 12, 2, 12, 12, 2, 12, 2};

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdy", rdy, 1);
        check("rst_dq_out_en", dq_out_en, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rdata_vld", rdata_vld, 0);
        check("rst_presence", presence, 0);
        check("rst_presence_vld", presence_vld, 0);
        check("dq_out_const", dq_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset with presence answer
        pres_mode = 1'b1;
        widths.delete();
        ps0 = pres_strobes;
        pres_exp_q.push_back(1'b1);
        issue(1, 0, 0, 8'h00);
        wait_idle(busy);
        check("pres_busy_cycles", busy, 43);
        check("pres_vld_first_idle", presence_vld, 1);
        check("pres_low_count", widths.size(), 1);
        if (widths.size() > 0) check("pres_low_width", widths[0], 25);
        @(negedge clk);
        check("pres_value", presence, 1);
        check("pres_strobe_count", pres_strobes - ps0, 1);

        // Reset without presence
        pres_mode = 1'b0;
        ps0 = pres_strobes;
        pres_exp_q.push_back(1'b0);
        issue(1, 0, 0, 8'h00);
        wait_idle(busy);
        @(negedge clk);
        check("nopres_value", presence, 0);
        check("nopres_strobe_count", pres_strobes - ps0, 1);

        // Write 0xA5
        widths.delete();
        rises.delete();
        rs0 = rd_strobes;
        issue(0, 1, 0, 8'hA5);
        wait_idle(busy);
        check("wr_busy_cycles", busy, 136);
        check("wr_low_count", widths.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < widths.size()) check($sformatf("wr_low_width_%0d", i), widths[i], exp_w[i]);
        end
        for (int i = 1; i < 8; i++) begin
            if (i < rises.size()) check($sformatf("wr_period_%0d", i), rises[i] - rises[i-1], 17);
        end
        check("wr_no_rdata_vld", rd_strobes - rs0, 0);

        // Read 0x3C
        widths.delete();
        rd_mode = 1'b1;
        rd_word = 8'h3C;
        bit_idx = 3'd0;
        rs0 = rd_strobes;
        rd_exp_q.push_back(8'h3C);
        issue(0, 0, 1, 8'h00);
        wait_idle(busy);
        check("rd_busy_cycles", busy, 136);
        check("rd_vld_first_idle", rdata_vld, 1);
        @(negedge clk);
        rd_mode = 1'b0;
        check("rd_low_count", widths.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < widths.size()) check($sformatf("rd_low_width_%0d", i), widths[i], 2);
        end
        check("rd_data", rdata, 8'h3C);
        check("rd_strobe_count", rd_strobes - rs0, 1);
        repeat (5) @(negedge clk);
        check("rd_data_hold", rdata, 8'h3C);

        // Simultaneous requests, then a write while busy
        pres_mode = 1'b1;
        widths.delete();
        pres_exp_q.push_back(1'b1);
        issue(1, 1, 1, 8'h00);
        repeat (3) @(negedge clk);
        issue(0, 1, 0, 8'h00);
        wait_idle(busy);
        check("prio_busy_cycles", busy + 4, 43);
        repeat (20) @(negedge clk);
        check("prio_low_count", widths.size(), 1);
        if (widths.size() > 0) check("prio_low_width", widths[0], 25);
        check("prio_still_idle", rdy, 1);
        pres_mode = 1'b0;

        // Abort a write during bit 3
        ps0 = pres_strobes;
        rs0 = rd_strobes;
        issue(0, 1, 0, 8'hA5);
        repeat (54) @(negedge clk);
        check("abort_bit3_low", dq_out_en, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_dq_released", dq_out_en, 0);
        check("abort_rdy", rdy, 1);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_no_pres_strobe", pres_strobes - ps0, 0);
        check("abort_no_rd_strobe", rd_strobes - rs0, 0);
        check("abort_rdata_cleared", rdata, 0);
        check("abort_stays_idle", rdy, 1);

        check("pres_queue_drained", pres_exp_q.size(), 0);
        check("rd_queue_drained", rd_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
